// File: rtl/rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter
//
// Shares one RGB status LED between NUM_REQ requesters. A round-robin arbiter
// picks one pending request while idle, latches its colour and duration,
// shows the colour for max(duration,1) cycles and then holds the LED blank
// for GAP_CYCLES cycles before it arbitrates again.
//
// Parameters
//   NUM_REQ    : number of requesters (>= 2)
//   DUR_WIDTH  : width of each per-requester duration field
//   GAP_CYCLES : forced blank cycles after every grant (0 allowed)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req        in   [NUM_REQ]            request bit per requester
//   req_color  in   [2*NUM_REQ]          colour code per requester
//                                        (00 blank, 01 red, 11 green, 10 blue)
//   req_dur    in   [DUR_WIDTH*NUM_REQ]  display cycles per requester
//   grant      out  [NUM_REQ]            one-hot, one-cycle acknowledge pulse
//   owner      out  [clog2(NUM_REQ)]     current / last granted requester
//   busy       out                       high while showing or in the gap
//   done       out                       pulse in the last show cycle
//   red/green/blue out                   LED drives, at most one high
// -----------------------------------------------------------------------------
module rgb_led_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DUR_WIDTH  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [2*NUM_REQ-1:0]          req_color,
    input  logic [DUR_WIDTH*NUM_REQ-1:0]  req_dur,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic                          done,
    output logic                          red,
    output logic                          green,
    output logic                          blue
);

    localparam int PTR_W = $clog2(NUM_REQ);
    // Always at least one bit wide, even when the gap is disabled.
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    localparam logic [DUR_WIDTH-1:0] DUR_ZERO = {DUR_WIDTH{1'b0}};
    localparam logic [DUR_WIDTH-1:0] DUR_ONE  = DUR_WIDTH'(1);
    localparam logic [GAP_W-1:0]     GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0]   ONEHOT_0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // First requesting index at or after the priority pointer, wrapping.
    // Offsets are scanned from the far end so the nearest hit is kept last.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [PTR_W-1:0]   p
    );
        logic [PTR_W-1:0] pick_v;
        logic [PTR_W-1:0] idx_v;
        pick_v = p;
        for (int offs = NUM_REQ - 1; offs >= 0; offs--) begin
            idx_v = PTR_W'((int'(p) + offs) % NUM_REQ);
            if (r[idx_v]) begin
                pick_v = idx_v;
            end else begin
                pick_v = pick_v;
            end
        end
        return pick_v;
    endfunction

    // Colour code to {red, green, blue}; blank and any unknown code give dark.
    function automatic logic [2:0] color_decode(input logic [1:0] code);
        logic [2:0] rgb_v;
        case (code)
            2'b01:   rgb_v = 3'b100;
            2'b11:   rgb_v = 3'b010;
            2'b10:   rgb_v = 3'b001;
            default: rgb_v = 3'b000;
        endcase
        return rgb_v;
    endfunction

    state_t                  state_r,   state_s;
    logic [PTR_W-1:0]        ptr_r,     ptr_s;
    logic [DUR_WIDTH-1:0]    dur_cnt_r, dur_cnt_s;
    logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_s;
    logic [1:0]              color_r,   color_s;
    logic [NUM_REQ-1:0]      grant_r,   grant_s;
    logic [PTR_W-1:0]        owner_r,   owner_s;
    logic                    busy_r,    busy_s;
    logic                    done_r,    done_s;
    logic [2:0]              rgb_r,     rgb_s;

    logic [PTR_W-1:0]        win_s;
    logic [DUR_WIDTH-1:0]    sel_dur_s;
    logic [1:0]              sel_color_s;
    logic [DUR_WIDTH-1:0]    dur_arr_s   [NUM_REQ];
    logic [1:0]              color_arr_s [NUM_REQ];

    // Unpack the flat per-requester colour and duration buses.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dur_arr_s[i]   = req_dur[i*DUR_WIDTH +: DUR_WIDTH];
            color_arr_s[i] = req_color[2*i +: 2];
        end
    end

    // Next-state, counter and registered-output computation for the FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        dur_cnt_s   = dur_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        color_s     = color_r;
        owner_s     = owner_r;
        grant_s     = {NUM_REQ{1'b0}};
        win_s       = rr_pick(req, ptr_r);
        sel_dur_s   = dur_arr_s[win_s];
        sel_color_s = color_arr_s[win_s];

        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s = ST_SHOW;
                    grant_s = ONEHOT_0 << win_s;
                    owner_s = win_s;
                    ptr_s   = PTR_W'((int'(win_s) + 1) % NUM_REQ);
                    color_s = sel_color_s;
                    // A zero duration still shows for one cycle.
                    if (sel_dur_s == DUR_ZERO) begin
                        dur_cnt_s = DUR_ZERO;
                    end else begin
                        dur_cnt_s = sel_dur_s - DUR_ONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (dur_cnt_r == DUR_ZERO) begin
                    if (GAP_CYCLES > 0) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = GAP_LOAD;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end else begin
                    dur_cnt_s = dur_cnt_r - DUR_ONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they line up with it
        // once registered.
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_SHOW) && (dur_cnt_s == DUR_ZERO);
        if (state_s == ST_SHOW) begin
            rgb_s = color_decode(color_s);
        end else begin
            rgb_s = 3'b000;
        end
    end

    // State, counters and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {PTR_W{1'b0}};
            dur_cnt_r <= DUR_ZERO;
            gap_cnt_r <= GAP_ZERO;
            color_r   <= 2'b00;
            grant_r   <= {NUM_REQ{1'b0}};
            owner_r   <= {PTR_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rgb_r     <= 3'b000;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            dur_cnt_r <= dur_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            color_r   <= color_s;
            grant_r   <= grant_s;
            owner_r   <= owner_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            rgb_r     <= rgb_s;
        end
    end

    assign grant = grant_r;
    assign owner = owner_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign red   = rgb_r[2];
    assign green = rgb_r[1];
    assign blue  = rgb_r[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rgb_led_arbiter
//
// Scoreboard bench. Stimulus pushes the expected grant sequence (winner,
// colour, show length, gap length, idle cycles before the grant) into a
// queue; a monitor samples the selected DUT on every falling edge, pops an
// entry whenever a grant appears and checks every following cycle.
// A second instance with GAP_CYCLES = 0 covers the no-gap path.
// -----------------------------------------------------------------------------
module tb_rgb_led_arbiter;

    localparam logic [2:0] RGB_R   = 3'b100;
    localparam logic [2:0] RGB_G   = 3'b010;
    localparam logic [2:0] RGB_B   = 3'b001;
    localparam logic [2:0] RGB_OFF = 3'b000;

    typedef struct {
        logic [1:0] win;
        logic [2:0] rgb;
        int         show;
        int         gap;
        int         idle_exp;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req0;
    logic [1:0]  col_a [4];
    logic [7:0]  dur_a [4];
    logic [7:0]  req_color;
    logic [31:0] req_dur;

    logic [3:0]  grant,   g_grant;
    logic [1:0]  owner,   g_owner;
    logic        busy,    g_busy;
    logic        done,    g_done;
    logic        red,     g_red;
    logic        green,   g_green;
    logic        blue,    g_blue;

    logic        sel;
    logic [3:0]  m_grant;
    logic [1:0]  m_owner;
    logic        m_busy, m_done, m_red, m_green, m_blue;

    exp_t        exp_q [$];
    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          cyc;

    assign req_color = {col_a[3], col_a[2], col_a[1], col_a[0]};
    assign req_dur   = {dur_a[3], dur_a[2], dur_a[1], dur_a[0]};

    assign m_grant = sel ? g_grant : grant;
    assign m_owner = sel ? g_owner : owner;
    assign m_busy  = sel ? g_busy  : busy;
    assign m_done  = sel ? g_done  : done;
    assign m_red   = sel ? g_red   : red;
    assign m_green = sel ? g_green : green;
    assign m_blue  = sel ? g_blue  : blue;

    rgb_led_arbiter #(.NUM_REQ(4), .DUR_WIDTH(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_color(req_color),
        .req_dur(req_dur), .grant(grant), .owner(owner), .busy(busy),
        .done(done), .red(red), .green(green), .blue(blue)
    );

    rgb_led_arbiter #(.NUM_REQ(4), .DUR_WIDTH(8), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .reset_n(reset_n), .req(req0), .req_color(req_color),
        .req_dur(req_dur), .grant(g_grant), .owner(g_owner), .busy(g_busy),
        .done(g_done), .red(g_red), .green(g_green), .blue(g_blue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic [1:0] win, input logic [2:0] rgb,
                        input int show, input int gap, input int idle_exp);
        exp_t e;
        e.win = win; e.rgb = rgb; e.show = show; e.gap = gap; e.idle_exp = idle_exp;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input logic [1:0] i, input logic [1:0] col, input logic [7:0] dur);
        col_a[i] = col;
        dur_a[i] = dur;
    endtask

    task automatic wait_grant(input logic [1:0] idx);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 600 && !seen; t++) begin
            @(negedge clk);
            if (m_grant[idx]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout cyc=%0d actual=none expected=grant[%0d]", cyc, idx);
        end
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: one comparison per sampled cycle against the scoreboard.
    initial begin
        exp_t        cur;
        bit          active;
        int          k;
        int          idle_cnt;
        logic [1:0]  last_owner;
        logic        prev_sel;
        logic [15:0] act_v;
        logic [15:0] exp_v;
        logic [3:0]  g_exp;
        logic        d_exp;
        logic [2:0]  c_exp;
        active = 1'b0; k = 0; idle_cnt = 0; last_owner = 2'd0; prev_sel = 1'b0;
        forever begin
            @(negedge clk);
            if (sel !== prev_sel) begin
                prev_sel   = sel;
                last_owner = 2'd0;
                idle_cnt   = 0;
            end
            if (reset_n !== 1'b1) begin
                active = 1'b0; idle_cnt = 0; last_owner = 2'd0;
            end else begin
                act_v = {5'd0, m_owner, m_grant, m_busy, m_done, m_red, m_green, m_blue};
                if (!active && m_grant != 4'd0 && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    if (cur.idle_exp >= 0) check("idle_before_grant", 16'(idle_cnt), 16'(cur.idle_exp));
                    active = 1'b1; k = 0; last_owner = cur.win;
                end
                if (active) begin
                    g_exp = (k == 0) ? (4'b0001 << cur.win) : 4'b0000;
                    d_exp = (k == cur.show - 1);
                    c_exp = (k < cur.show) ? cur.rgb : RGB_OFF;
                    exp_v = {5'd0, cur.win, g_exp, 1'b1, d_exp, c_exp};
                    check("active_cycle", act_v, exp_v);
                    k++;
                    if (k >= cur.show + cur.gap) begin
                        active = 1'b0; idle_cnt = 0;
                    end
                end else begin
                    exp_v = {5'd0, last_owner, 4'b0000, 1'b0, 1'b0, RGB_OFF};
                    check("idle_cycle", act_v, exp_v);
                    idle_cnt++;
                end
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        sel = 1'b0; reset_n = 1'b0; req = 4'd0; req0 = 4'd0;
        col_a = '{default: 2'b00};
        dur_a = '{default: 8'd0};

        repeat (2) @(negedge clk);
        check("reset_outputs", {5'd0, owner, grant, busy, done, red, green, blue}, 16'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Round-robin, all requesting, duration 1: 0,1,2,3,0.
        set_req(2'd0, 2'b01, 8'd1); set_req(2'd1, 2'b11, 8'd1);
        set_req(2'd2, 2'b10, 8'd1); set_req(2'd3, 2'b11, 8'd1);
        push(2'd0, RGB_R, 1, 2, -1); push(2'd1, RGB_G, 1, 2, 1);
        push(2'd2, RGB_B, 1, 2, 1);  push(2'd3, RGB_G, 1, 2, 1);
        push(2'd0, RGB_R, 1, 2, 1);
        req = 4'b1111;
        wait_grant(2'd0); wait_grant(2'd1); wait_grant(2'd2);
        wait_grant(2'd3); wait_grant(2'd0);
        req = 4'b0000;
        idle_wait(6);

        // Single red request, duration 3 (pointer now 1, still wins).
        set_req(2'd0, 2'b01, 8'd3);
        push(2'd0, RGB_R, 3, 2, -1);
        req = 4'b0001;
        wait_grant(2'd0);
        req = 4'b0000;
        idle_wait(8);

        // Priority rotation: after requester 2, 0101 goes to 0, then 2.
        set_req(2'd2, 2'b10, 8'd2);
        push(2'd2, RGB_B, 2, 2, -1);
        req = 4'b0100;
        wait_grant(2'd2);
        push(2'd0, RGB_R, 3, 2, 1);
        push(2'd2, RGB_B, 2, 2, 1);
        req = 4'b0101;
        wait_grant(2'd0);
        req = 4'b0100;
        wait_grant(2'd2);
        req = 4'b0000;
        idle_wait(6);

        // Boundary: duration 0 with blank colour, then duration 255.
        set_req(2'd3, 2'b00, 8'd0);
        push(2'd3, RGB_OFF, 1, 2, -1);
        req = 4'b1000;
        wait_grant(2'd3);
        req = 4'b0000;
        idle_wait(5);
        set_req(2'd1, 2'b11, 8'd255);
        push(2'd1, RGB_G, 255, 2, -1);
        req = 4'b0010;
        wait_grant(2'd1);
        req = 4'b0000;
        idle_wait(262);

        // Withdrawal: requester 2 pulses during requester 0's show.
        set_req(2'd0, 2'b01, 8'd4);
        push(2'd0, RGB_R, 4, 2, -1);
        req = 4'b0001;
        wait_grant(2'd0);
        req = 4'b0000;
        idle_wait(1);
        req = 4'b0100;
        idle_wait(1);
        req = 4'b0000;
        idle_wait(10);

        // Reset in the second cycle of a 5-cycle green.
        set_req(2'd1, 2'b11, 8'd5);
        push(2'd1, RGB_G, 5, 2, -1);
        req = 4'b0010;
        wait_grant(2'd1);
        req = 4'b0000;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_green", {15'd0, green}, 16'd0);
        check("rst_busy",  {15'd0, busy},  16'd0);
        check("rst_owner", {14'd0, owner}, 16'd0);
        idle_wait(2);
        reset_n = 1'b1;
        @(negedge clk);
        // Pointer back at 0: 1010 must pick 1, then 1000 picks 3.
        set_req(2'd3, 2'b00, 8'd0);
        push(2'd1, RGB_G, 5, 2, -1);
        push(2'd3, RGB_OFF, 1, 2, 1);
        req = 4'b1010;
        wait_grant(2'd1);
        req = 4'b1000;
        wait_grant(2'd3);
        req = 4'b0000;
        idle_wait(6);

        // GAP_CYCLES = 0 instance: SHOW straight to IDLE, one idle cycle.
        @(posedge clk);
        #1 sel = 1'b1;
        @(negedge clk);
        set_req(2'd0, 2'b01, 8'd2);
        set_req(2'd1, 2'b11, 8'd3);
        push(2'd0, RGB_R, 2, 0, -1);
        push(2'd1, RGB_G, 3, 0, 1);
        req0 = 4'b0011;
        wait_grant(2'd0);
        req0 = 4'b0010;
        wait_grant(2'd1);
        req0 = 4'b0000;
        idle_wait(6);

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
